// File: rtl/seven_decimal_capture.sv
// -----------------------------------------------------------------------------
// seven_decimal_capture
//
// Receive side of a scanned seven-segment decimal display. Samples the
// multiplexed segment bus every cycle, waits for the (an, ca) pair to stay
// identical for STABLE_CYCLES samples, then commits the decoded digit for the
// single active digit select. Used to self-check or mirror display output.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   an           one-hot active-high digit select (all zero = blanking gap)
//   ca           segment bus, [6:0] = segments g..a, [7] = decimal point
//   clr_flags    clears the sticky error flags (a coincident set wins)
//   digits       decoded value per digit, digit i at [4i+3:4i]
//                (F = blank, E = illegal pattern)
//   points       captured decimal point per digit
//   digit_valid  digit i holds a legal 0-9 value
//   update       one-cycle pulse after a digit commit
//   update_idx   index of the committed digit, meaningful while update is high
//   bad_seg      sticky: a non-blank pattern outside the 0-9 table was committed
//   bad_an       sticky: a stable select with two or more bits set was seen
// -----------------------------------------------------------------------------
module seven_decimal_capture #(
   parameter  int NUM_DIGITS    = 4,
   parameter  int STABLE_CYCLES = 4,
   localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic [7:0]              ca,
   input  logic                    clr_flags,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   points,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    update,
   output logic [IDX_W-1:0]        update_idx,
   output logic                    bad_seg,
   output logic                    bad_an
);

   localparam int              CNT_W      = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);

   logic [NUM_DIGITS-1:0]   r_an_q;
   logic [7:0]              r_ca_q;
   logic [CNT_W-1:0]        r_cnt;
   logic [4*NUM_DIGITS-1:0] r_digits;
   logic [NUM_DIGITS-1:0]   r_points;
   logic [NUM_DIGITS-1:0]   r_valid;
   logic                    r_update;
   logic [IDX_W-1:0]        r_update_idx;
   logic                    r_bad_seg;
   logic                    r_bad_an;

   logic                    w_held;
   logic                    w_at_commit;
   logic                    w_onehot;
   logic                    w_commit;
   logic                    w_bad_an_set;
   logic                    w_bad_seg_set;
   logic [IDX_W-1:0]        w_idx;
   logic [3:0]              w_dec_val;
   logic                    w_dec_blank;
   logic                    w_dec_bad;

   assign w_held   = (an == r_an_q) && (ca == r_ca_q);
   // The counter only reaches CNT_COMMIT once per run (it saturates above it),
   // so this edge is the STABLE_CYCLES-th identical sample and fires once.
   assign w_at_commit   = w_held && (r_cnt == CNT_COMMIT);
   assign w_onehot      = $onehot(an);
   assign w_commit      = w_at_commit && w_onehot;
   assign w_bad_an_set  = w_at_commit && !w_onehot && (an != '0);
   assign w_bad_seg_set = w_commit && w_dec_bad;

   // Index of the active select bit; only used when an is one-hot.
   always_comb begin
      w_idx = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (an[k]) w_idx = IDX_W'(k);
      end
   end

   // Exact-match segment decode. Blank maps to F, anything else unknown to E.
   always_comb begin
      w_dec_val   = 4'hE;
      w_dec_blank = 1'b0;
      w_dec_bad   = 1'b0;
      case (ca[6:0])
         7'b0111111: w_dec_val = 4'd0;
         7'b0000110: w_dec_val = 4'd1;
         7'b1011011: w_dec_val = 4'd2;
         7'b1001111: w_dec_val = 4'd3;
         7'b1100110: w_dec_val = 4'd4;
         7'b1101101: w_dec_val = 4'd5;
         7'b1111101: w_dec_val = 4'd6;
         7'b0000111: w_dec_val = 4'd7;
         7'b1111111: w_dec_val = 4'd8;
         7'b1101111: w_dec_val = 4'd9;
         7'b0000000: begin
            w_dec_val   = 4'hF;
            w_dec_blank = 1'b1;
         end
         default: w_dec_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_an_q       <= '0;
         r_ca_q       <= '0;
         r_cnt        <= '0;
         r_digits     <= '1;
         r_points     <= '0;
         r_valid      <= '0;
         r_update     <= 1'b0;
         r_update_idx <= '0;
         r_bad_seg    <= 1'b0;
         r_bad_an     <= 1'b0;
      end else begin
         r_an_q <= an;
         r_ca_q <= ca;

         if (!w_held) begin
            r_cnt <= CNT_ONE;
         end else if (r_cnt < CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
         end

         r_update <= w_commit;
         if (w_commit) begin
            r_update_idx <= w_idx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (an[i]) begin
                  r_points[i]       <= ca[7];
                  r_digits[4*i +: 4] <= w_dec_val;
                  r_valid[i]        <= !w_dec_blank && !w_dec_bad;
               end
            end
         end

         // Set has priority over clear.
         r_bad_seg <= (r_bad_seg && !clr_flags) || w_bad_seg_set;
         r_bad_an  <= (r_bad_an  && !clr_flags) || w_bad_an_set;
      end
   end

   assign digits      = r_digits;
   assign points      = r_points;
   assign digit_valid = r_valid;
   assign update      = r_update;
   assign update_idx  = r_update_idx;
   assign bad_seg     = r_bad_seg;
   assign bad_an      = r_bad_an;

endmodule

// File: tb/tb_seven_decimal_capture.sv
// -----------------------------------------------------------------------------
// tb_seven_decimal_capture
//
// Directed bench for seven_decimal_capture (NUM_DIGITS=4, STABLE_CYCLES=4).
// A behavioural model tracks the length of the current run of identical
// (an, ca) samples and applies the commit rules; one compare process checks
// every output against it each cycle, and literal expectations pin the model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seven_decimal_capture;

  localparam int ND = 4;
  localparam int SC = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [ND-1:0]   an;
  logic [7:0]      ca;
  logic            clr_flags;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   points;
  logic [ND-1:0]   digit_valid;
  logic            update;
  logic [1:0]      update_idx;
  logic            bad_seg;
  logic            bad_an;

  seven_decimal_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .an         (an),
    .ca         (ca),
    .clr_flags  (clr_flags),
    .digits     (digits),
    .points     (points),
    .digit_valid(digit_valid),
    .update     (update),
    .update_idx (update_idx),
    .bad_seg    (bad_seg),
    .bad_an     (bad_an)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int upd_cnt = 0;
  bit check_en = 1'b0;
  logic [1:0] exp_q[$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111};

  // 0-9 for a table hit, 15 for blank, 14 for anything else
  function automatic int decode(input logic [6:0] seg);
    if (seg == 7'd0) return 15;
    for (int v = 0; v < 10; v++) if (seg_tab[v] == seg) return v;
    return 14;
  endfunction

  logic [3:0]    m_dig [ND];
  logic [ND-1:0] m_pts, m_val;
  logic          m_update, m_bad_seg, m_bad_an;
  logic [1:0]    m_idx;
  int            m_run;
  logic [ND-1:0] m_last_an;
  logic [7:0]    m_last_ca;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ND; i++) m_dig[i] = 4'hF;
      m_pts = '0; m_val = '0; m_update = 1'b0; m_idx = '0;
      m_bad_seg = 1'b0; m_bad_an = 1'b0;
      m_run = 0;
    end else begin
      logic set_seg, set_an;
      int v, idx;
      set_seg = 1'b0;
      set_an  = 1'b0;
      if (m_run == 0 || an != m_last_an || ca != m_last_ca) m_run = 1;
      else if (m_run < 1000) m_run++;
      m_last_an = an;
      m_last_ca = ca;
      m_update = 1'b0;
      if (m_run == SC) begin
        if ($countones(an) == 1) begin
          idx = 0;
          for (int i = 0; i < ND; i++) if (an[i]) idx = i;
          v = decode(ca[6:0]);
          m_dig[idx] = 4'(v);
          m_val[idx] = (v < 10);
          m_pts[idx] = ca[7];
          set_seg    = (v == 14);
          m_update   = 1'b1;
          m_idx      = 2'(idx);
          exp_q.push_back(2'(idx));
        end else if (an != '0) begin
          set_an = 1'b1;
        end
      end
      m_bad_seg = (m_bad_seg && !clr_flags) || set_seg;
      m_bad_an  = (m_bad_an  && !clr_flags) || set_an;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      logic [4*ND-1:0] m_dig_v;
      for (int i = 0; i < ND; i++) m_dig_v[4*i +: 4] = m_dig[i];
      check("digits", digits, m_dig_v);
      check("points", points, m_pts);
      check("digit_valid", digit_valid, m_val);
      check("update", update, m_update);
      check("bad_seg", bad_seg, m_bad_seg);
      check("bad_an", bad_an, m_bad_an);
      if (update) begin
        upd_cnt++;
        check("update_idx", update_idx, m_idx);
        if (exp_q.size() > 0) check("sb_idx", update_idx, exp_q.pop_front());
        else check("sb_queue_depth", exp_q.size(), 1);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic hold(input logic [ND-1:0] a, input logic [7:0] c, input int n);
    an = a;
    ca = c;
    repeat (n) @(negedge clk);
  endtask

  int u0;

  initial begin
    rst_n = 1'b0; an = '0; ca = '0; clr_flags = 1'b0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    #1;
    check("rst_digits", digits, 16'hFFFF);
    check("rst_points", points, 4'b0000);
    check("rst_valid", digit_valid, 4'b0000);
    check("rst_update", update, 1'b0);
    check("rst_idx", update_idx, 2'd0);
    check("rst_bad_seg", bad_seg, 1'b0);
    check("rst_bad_an", bad_an, 1'b0);

    // single digit commit: 3 on digit 0
    rst_n = 1'b1;
    u0 = upd_cnt;
    hold(4'b0001, 8'h4F, 4); #1;
    check("t1_update", update, 1'b1);
    check("t1_idx", update_idx, 2'd0);
    check("t1_digit0", digits[3:0], 4'd3);
    check("t1_valid", digit_valid, 4'b0001);
    check("t1_points", points, 4'b0000);
    check("t1_pulses", upd_cnt - u0, 1);

    // two round-robin scans of 1, 2, 8., 0
    u0 = upd_cnt;
    repeat (2) begin
      hold(4'b0001, 8'h06, 10);
      hold(4'b0010, 8'h5B, 10);
      hold(4'b0100, 8'hFF, 10);
      hold(4'b1000, 8'h3F, 10);
    end
    #1;
    check("t2_digits", digits, 16'h0821);
    check("t2_points", points, 4'b0100);
    check("t2_valid", digit_valid, 4'b1111);
    check("t2_pulses", upd_cnt - u0, 8);

    // glitch: a 3-sample "1" must not commit, the following 8 does
    u0 = upd_cnt;
    hold(4'b0010, 8'h06, 3);
    hold(4'b0010, 8'h7F, 5); #1;
    check("t3_digits", digits, 16'h0881);
    check("t3_pulses", upd_cnt - u0, 1);

    // illegal pattern, then clear the sticky flag
    hold(4'b0010, 8'h49, 4); #1;
    check("t4_digit1", digits[7:4], 4'hE);
    check("t4_valid1", digit_valid[1], 1'b0);
    check("t4_bad_seg", bad_seg, 1'b1);
    clr_flags = 1'b1;
    hold(4'b0010, 8'h49, 1);
    clr_flags = 1'b0; #1;
    check("t4_clr_bad_seg", bad_seg, 1'b0);
    check("t4_digit1_kept", digits[7:4], 4'hE);

    // two selects active, then blanking gap
    u0 = upd_cnt;
    hold(4'b0011, 8'h06, 6); #1;
    check("t5_bad_an", bad_an, 1'b1);
    check("t5_pulses", upd_cnt - u0, 0);
    hold(4'b0000, 8'h00, 6); #1;
    check("t5_gap_bad_an", bad_an, 1'b1);
    check("t5_gap_pulses", upd_cnt - u0, 0);

    // reset mid-run discards the partial count
    hold(4'b0100, 8'h66, 2);
    rst_n = 1'b0;
    hold(4'b0100, 8'h66, 2); #1;
    check("t6_rst_digits", digits, 16'hFFFF);
    check("t6_rst_valid", digit_valid, 4'b0000);
    check("t6_rst_bad_an", bad_an, 1'b0);
    rst_n = 1'b1;
    u0 = upd_cnt;
    hold(4'b0100, 8'h66, 3); #1;
    check("t6_early_pulses", upd_cnt - u0, 0);
    hold(4'b0100, 8'h66, 1); #1;
    check("t6_update", update, 1'b1);
    check("t6_idx", update_idx, 2'd2);
    check("t6_digit2", digits[11:8], 4'd4);
    check("t6_valid", digit_valid, 4'b0100);

    // blank digit with point: value F, not valid, no error
    hold(4'b0001, 8'h80, 4); #1;
    check("t7_digit0", digits[3:0], 4'hF);
    check("t7_valid0", digit_valid[0], 1'b0);
    check("t7_point0", points[0], 1'b1);
    check("t7_bad_seg", bad_seg, 1'b0);

    // set wins over a simultaneous clear
    clr_flags = 1'b1;
    hold(4'b1000, 8'h01, 4);
    clr_flags = 1'b0; #1;
    check("t8_set_wins", bad_seg, 1'b1);
    check("t8_digit3", digits[15:12], 4'hE);

    hold(4'b0000, 8'h00, 3); #1;
    check("sb_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_decimal_capture.md
Name: seven_decimal_capture

Overview:
- Receive-side counterpart of the seven-segment decimal encoder.
- Watches a scanned, multiplexed display bus (active-high segments `ca[7:0]`, `ca[7]` = decimal point; one-hot active-high digit select `an`).
- Recovers the decimal value and point of every digit. Used for on-chip self-check of display output and for mirroring the display to debug logic.
- Filters scan transients with a stability counter before committing a digit.

Parameters:
- NUM_DIGITS, 4: number of display digits (width of `an`).
- STABLE_CYCLES, 4: consecutive identical samples required before commit. Legal range is 2 to 255.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- an  input  NUM_DIGITS  digit select, one-hot, active-high.
- ca  input  8  segment bus; bits [6:0] are segments g..a, bit [7] is the point.
- clr_flags  input  1  synchronous clear of the sticky error flags.
- digits  output  4*NUM_DIGITS  decoded value per digit; digit i occupies [4i+3:4i].
- points  output  NUM_DIGITS  captured point per digit.
- digit_valid  output  NUM_DIGITS  digit i holds a legal 0-9 value.
- update  output  1  one-cycle pulse when a digit is committed.
- update_idx  output  $clog2(NUM_DIGITS) (minimum 1)  index of the committed digit; valid while `update` is high.
- bad_seg  output  1  sticky: a non-blank pattern outside the 0-9 table was committed.
- bad_an  output  1  sticky: a stable non-one-hot, non-zero `an` was seen.

Behaviour:
- Reset, when `rst_n` is low at a clk edge:
  - digits = all 4'hF, points = 0, digit_valid = 0, update = 0, update_idx = 0.
  - bad_seg = 0, bad_an = 0.
  - Internal an_q = 0, ca_q = 0, cnt = 0.
  - Reset mid-run discards any partial stability count.
- Sampling, every edge: `held` = (an == an_q) and (ca == ca_q); an_q <= an, ca_q <= ca.
- Counter:
  - If not held, cnt <= 1.
  - Else if cnt < STABLE_CYCLES, cnt <= cnt + 1.
  - Else cnt holds, saturated at STABLE_CYCLES.
  - cnt width is $clog2(STABLE_CYCLES+1).
- Commit: fires at the edge where held, cnt == STABLE_CYCLES-1, and an is exactly one-hot.
  - This is the STABLE_CYCLES-th identical sample.
  - Exactly one commit per stable run; the run does not commit again until an or ca changes.
- On commit for digit i (the index of the set bit in an), at the same edge:
  - update <= 1 and update_idx <= i. `update` is 0 on all other cycles, so it is visible the cycle after that edge.
  - points[i] <= ca[7].
  - ca[6:0] decodes by exact match:
    - 0: 0111111
    - 1: 0000110
    - 2: 1011011
    - 3: 1001111
    - 4: 1100110
    - 5: 1101101
    - 6: 1111101
    - 7: 0000111
    - 8: 1111111
    - 9: 1101111
  - Match: digits[i] <= value, digit_valid[i] <= 1.
  - ca[6:0] == 0 (blank): digits[i] <= 4'hF, digit_valid[i] <= 0; no error.
  - Any other pattern: digits[i] <= 4'hE, digit_valid[i] <= 0, bad_seg <= 1.
- Other digits are unchanged by a commit.
- an == 0: never commits and is not an error (scan blanking gap).
- an with 2 or more bits set: no commit. bad_an <= 1 at the edge where the commit condition would otherwise hold.
- Sticky flags:
  - clr_flags high clears bad_seg and bad_an at the edge.
  - If a set event coincides with clr_flags, the set wins.
- Output latency: from the first edge sampling a new stable (an, ca), update is visible after STABLE_CYCLES edges.
- Glitch rejection: an (an, ca) value held for fewer than STABLE_CYCLES samples produces no output change.

Test Plan:
- Reset, then an=0001, ca=0x4F held 4 cycles -> one update pulse with idx 0; digits[3:0]=3, digit_valid=0001, points=0000.
- Round-robin scan of digits 0-3 with 1, 2, 8, 0 (ca[7]=1 on digit 2), 10 cycles per digit -> digits=0x0821, points=0100, digit_valid=1111, exactly 4 update pulses per scan.
- Glitch: digit 1 shows 0x06 for 3 cycles, then 0x7F for 5 cycles -> no commit of 1; a single commit of 8 on idx 1.
- Bad pattern: an=0010, ca=0x49 held 4 cycles -> digits[7:4]=E, digit_valid[1]=0, bad_seg=1; pulse clr_flags -> bad_seg=0, digit value retained.
- an=0011 held 6 cycles -> no update, bad_an=1. Then an=0000 held -> bad_an stays 1, no update.
- Reset asserted at cnt=2 mid-run, released with inputs unchanged -> commit occurs only 4 edges after release; all outputs at reset values meanwhile.
